// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: column-scanning driver for a 4x4 matrix keypad.
// Drives one active-low column at a time and samples the synchronized rows
// at the end of each column dwell. A scan result is accepted only when exactly
// one key was seen in a full scan, which also rejects ghosting. The result is
// then debounced over DEBOUNCE_SCANS identical scans before it is committed.
// Output codes: 0 = no key, otherwise code = col*4 + row + 1.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | committed value is 0 and the candidate agrees with it
// ARMING  | candidate differs from the committed value
// HELD    | committed value is nonzero and the candidate agrees
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [3:0] Keypad_Col_O,
    input  logic [3:0] Keypad_Row_I,
    output logic [5:0] Keyb_Value,
    output logic       Key_Valid,
    output logic       Key_Strobe
);

    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_N    = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMING = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_col_o;
    logic [4:0]       r_acc;
    logic [1:0]       r_hits;
    logic [4:0]       r_cand;
    logic [3:0]       r_stable;
    logic [1:0]       r_state;
    logic [4:0]       r_value;
    logic             r_valid;
    logic             r_strobe;

    logic             w_sample;
    logic             w_scan_end;
    logic [3:0]       w_pressed;
    logic [2:0]       w_col_cnt;
    logic [1:0]       w_row;
    logic [4:0]       w_col_code;
    logic [2:0]       w_hits_sum;
    logic [1:0]       w_hits_new;
    logic [4:0]       w_acc_new;
    logic [4:0]       w_scan_res;
    logic [3:0]       w_stable_next;
    logic             w_commit;
    logic [1:0]       w_state_next;

    assign w_sample   = (r_div == DIV_LAST);
    assign w_scan_end = w_sample && (r_col == 2'd3);
    assign w_pressed  = ~r_row_sync;
    assign w_col_cnt  = 3'(w_pressed[0]) + 3'(w_pressed[1]) +
                        3'(w_pressed[2]) + 3'(w_pressed[3]);

    // Lowest pressed row in this column gives the lowest code.
    assign w_row      = w_pressed[0] ? 2'd0 :
                        w_pressed[1] ? 2'd1 :
                        w_pressed[2] ? 2'd2 : 2'd3;
    assign w_col_code = {1'b0, r_col, w_row} + 5'd1;

    // Hit count saturates at 2: anything beyond one key is simply "too many".
    assign w_hits_sum = {1'b0, r_hits} + w_col_cnt;
    assign w_hits_new = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
    assign w_acc_new  = (r_acc != 5'd0)     ? r_acc :
                        (w_col_cnt != 3'd0) ? w_col_code : 5'd0;
    assign w_scan_res = (w_hits_new == 2'd1) ? w_acc_new : 5'd0;

    // The candidate always becomes this scan's result, so the commit test
    // compares the scan result directly against the committed value.
    assign w_stable_next = (w_scan_res != r_cand) ? 4'd1 :
                           (r_stable >= DEB_N)    ? DEB_N : r_stable + 4'd1;
    assign w_commit      = (w_stable_next == DEB_N) && (w_scan_res != r_value);

    assign Keypad_Col_O = r_col_o;
    assign Keyb_Value   = {1'b0, r_value};
    assign Key_Valid    = r_valid;
    assign Key_Strobe   = r_strobe;

    // Two-flop synchronizer for the asynchronous row inputs (idle high).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= Keypad_Row_I;
            r_row_sync <= r_row_meta;
        end
    end

    // Column dwell counter and registered one-cold column drive.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_div   <= '0;
            r_col   <= 2'd0;
            r_col_o <= 4'b1110;
        end else if (w_sample) begin
            r_div   <= '0;
            r_col   <= r_col + 2'd1;
            r_col_o <= ~(4'b0001 << (r_col + 2'd1));
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // Per-scan accumulation of the first hit and the number of hits.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_acc  <= 5'd0;
            r_hits <= 2'd0;
        end else if (w_scan_end) begin
            r_acc  <= 5'd0;
            r_hits <= 2'd0;
        end else if (w_sample) begin
            r_acc  <= w_acc_new;
            r_hits <= w_hits_new;
        end
    end

    // Debounce next-state decode, evaluated only at end of scan.
    always_comb begin
        w_state_next = r_state;
        if (w_scan_end) begin
            if (w_commit) begin
                w_state_next = (w_scan_res != 5'd0) ? ST_HELD : ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_scan_res != r_value) w_state_next = ST_ARMING;
                    end
                    ST_ARMING: begin
                        if (w_scan_res == r_value)
                            w_state_next = (r_value != 5'd0) ? ST_HELD : ST_IDLE;
                    end
                    ST_HELD: begin
                        if (w_scan_res != r_value) w_state_next = ST_ARMING;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end
        end
    end

    // Debounce registers, committed value and one-cycle strobe on new key.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cand   <= 5'd0;
            r_stable <= 4'd0;
            r_state  <= ST_IDLE;
            r_value  <= 5'd0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_state  <= w_state_next;
            if (w_scan_end) begin
                r_cand   <= w_scan_res;
                r_stable <= w_stable_next;
                if (w_commit) begin
                    r_value  <= w_scan_res;
                    r_valid  <= (w_scan_res != 5'd0);
                    r_strobe <= (w_scan_res != 5'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// Keys change only just after a scan boundary, so each scan sees one key set;
// the reference model turns that set into a scan code and debounces it.
module tb_keypad_scanner_4x4;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Keypad_Col_O;
    logic [3:0]  Keypad_Row_I;
    logic [5:0]  Keyb_Value;
    logic        Key_Valid;
    logic        Key_Strobe;

    logic [15:0] keys = '0;
    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;
    int strobe_cnt  = 0;
    int m_cand      = 0;
    int m_stable    = 0;
    int m_value     = 0;

    keypad_scanner_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Keypad_Col_O (Keypad_Col_O),
        .Keypad_Row_I (Keypad_Row_I),
        .Keyb_Value   (Keyb_Value),
        .Key_Valid    (Key_Valid),
        .Key_Strobe   (Key_Strobe)
    );

    always #5 Clock = ~Clock;

    // Matrix model: pressed key (c,r) pulls row r low while column c is driven low.
    always_comb begin
        Keypad_Row_I = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4 + r] && !Keypad_Col_O[c]) Keypad_Row_I[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scan_code(input logic [15:0] m);
        if ($countones(m) != 1) return 0;
        for (int i = 0; i < 16; i++)
            if (m[i]) return i + 1;
        return 0;
    endfunction

    // One clock: column drive follows the edge count since reset release.
    task automatic tick();
        logic [3:0] exp_col;
        @(posedge Clock);
        #1;
        k++;
        exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
        chk("col_drive", {28'd0, Keypad_Col_O}, {28'd0, exp_col});
        if (Key_Strobe === 1'b1) strobe_cnt++;
    endtask

    // One full scan with key set m, then compare against the model.
    task automatic scan(input logic [15:0] m);
        int res;
        int exp_strobe;
        keys       = m;
        strobe_cnt = 0;
        repeat (SCAN_CYC) tick();
        res        = scan_code(m);
        exp_strobe = 0;
        if (res == m_cand) begin
            if (m_stable < DEB) m_stable++;
        end else begin
            m_cand   = res;
            m_stable = 1;
        end
        if (m_stable == DEB && m_cand != m_value) begin
            m_value    = m_cand;
            exp_strobe = (m_value != 0) ? 1 : 0;
        end
        chk("keyb_value",   {26'd0, Keyb_Value}, m_value);
        chk("key_valid",    {31'd0, Key_Valid},  (m_value != 0) ? 1 : 0);
        chk("strobe_count", strobe_cnt,          exp_strobe);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_value"},  {26'd0, Keyb_Value},   0);
        chk({tag, "_valid"},  {31'd0, Key_Valid},    0);
        chk({tag, "_strobe"}, {31'd0, Key_Strobe},   0);
        chk({tag, "_col"},    {28'd0, Keypad_Col_O}, 32'hE);
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset    = 1'b0;
        k        = 0;
        m_cand   = 0;
        m_stable = 0;
        m_value  = 0;
    endtask

    initial begin
        logic [15:0] cur;
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // Idle: column walk, nothing committed.
        repeat (2) scan(16'h0000);

        // '5' (col1,row1) -> code 6 on the third scan.
        repeat (2) scan(16'h0020);
        chk("t2_not_yet", {26'd0, Keyb_Value}, 0);
        scan(16'h0020);
        chk("t2_commit", {26'd0, Keyb_Value}, 6);
        repeat (2) scan(16'h0020);
        chk("t2_hold", {26'd0, Keyb_Value}, 6);
        repeat (3) scan(16'h0000);

        // '#' (col2,row3): 2 present, 1 gap, 3 present -> 12 only at the end.
        repeat (2) scan(16'h0800);
        scan(16'h0000);
        repeat (2) scan(16'h0800);
        chk("t3_not_yet", {26'd0, Keyb_Value}, 0);
        scan(16'h0800);
        chk("t3_commit", {26'd0, Keyb_Value}, 12);
        repeat (3) scan(16'h0000);

        // '1' + 'A' together is rejected; '1' alone then commits 1.
        repeat (4) scan(16'h1001);
        chk("t4_multi", {26'd0, Keyb_Value}, 0);
        repeat (3) scan(16'h0001);
        chk("t4_single", {26'd0, Keyb_Value}, 1);
        repeat (3) scan(16'h0000);

        // 6 -> 'D' (16) directly, then release.
        repeat (3) scan(16'h0020);
        repeat (3) scan(16'h8000);
        chk("t5_switch", {26'd0, Keyb_Value}, 16);
        repeat (3) scan(16'h0000);
        chk("t5_release", {31'd0, Key_Valid}, 0);

        // Reset mid-dwell with '5' committed and still held.
        repeat (3) scan(16'h0020);
        repeat (6) tick();
        #2 Reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        release_reset();
        repeat (3) scan(16'h0020);
        chk("t6_recommit", {26'd0, Keyb_Value}, 6);

        // Random key sequences with runs long enough to commit.
        cur = 16'h0020;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2:       cur = 16'h0000;
                    3, 4, 5, 6, 7: cur = 16'h0001 << $urandom_range(0, 15);
                    default:       cur = (16'h0001 << $urandom_range(0, 15)) |
                                         (16'h0001 << $urandom_range(0, 15));
                endcase
            end
            scan(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
